// File: rtl/uart_wb_arbiter.sv
// Two-master Wishbone arbiter for the shared UART slave port: round-robin on contention, grant held for whole cycles.
// Optional stall watchdog compiled in with `define UART_WB_ARB_TIMEOUT_EN; aborts a transfer after TIMEOUT_CYCLES stalled strobes.
module uart_wb_arbiter #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_n_i,

    input  logic        m0_wbs_cyc_i,
    input  logic        m0_wbs_stb_i,
    input  logic        m0_wbs_we_i,
    input  logic [31:0] m0_wbs_adr_i,
    input  logic [31:0] m0_wbs_dat_i,
    input  logic [3:0]  m0_wbs_sel_i,
    output logic [31:0] m0_wbs_dat_o,
    output logic        m0_wbs_ack_o,

    input  logic        m1_wbs_cyc_i,
    input  logic        m1_wbs_stb_i,
    input  logic        m1_wbs_we_i,
    input  logic [31:0] m1_wbs_adr_i,
    input  logic [31:0] m1_wbs_dat_i,
    input  logic [3:0]  m1_wbs_sel_i,
    output logic [31:0] m1_wbs_dat_o,
    output logic        m1_wbs_ack_o,

    output logic        s_wbs_cyc_o,
    output logic        s_wbs_stb_o,
    output logic        s_wbs_we_o,
    output logic [31:0] s_wbs_adr_o,
    output logic [31:0] s_wbs_dat_o,
    output logic [3:0]  s_wbs_sel_o,
    input  logic [31:0] s_wbs_dat_i,
    input  logic        s_wbs_ack_i,

    output logic [1:0]  gnt_o,
    output logic        timeout_o
);

    if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 1023) begin : g_bad_timeout
        $error("uart_wb_arbiter: TIMEOUT_CYCLES must be within 1..1023");
    end

    // Encoding doubles as the one-hot grant vector.
    typedef enum logic [1:0] {
        IDLE = 2'b00,
        GNT0 = 2'b01,
        GNT1 = 2'b10
    } state_t;

    state_t state_q, state_d;
    logic   rr_q, rr_d;
    logic   req0, req1;
    logic   granted;
    logic   fire;

    assign req0    = m0_wbs_cyc_i & m0_wbs_stb_i;
    assign req1    = m1_wbs_cyc_i & m1_wbs_stb_i;
    assign granted = (state_q == GNT0) || (state_q == GNT1);

    always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
        if (!wb_rst_n_i) begin
            state_q <= IDLE;
            rr_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            rr_q    <= rr_d;
        end
    end

    // rr_q names the master that wins the next tie: 0 = m0, 1 = m1.
    always_comb begin
        state_d = state_q;
        rr_d    = rr_q;
        case (state_q)
            IDLE: begin
                if (req0 && req1) begin
                    state_d = rr_q ? GNT1 : GNT0;
                    rr_d    = ~rr_q;
                end else if (req0) begin
                    state_d = GNT0;
                    rr_d    = 1'b1;
                end else if (req1) begin
                    state_d = GNT1;
                    rr_d    = 1'b0;
                end
            end
            GNT0:    if (!m0_wbs_cyc_i) state_d = IDLE;
            GNT1:    if (!m1_wbs_cyc_i) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

`ifdef UART_WB_ARB_TIMEOUT_EN
    localparam logic [9:0] TIMEOUT_LIM = 10'(TIMEOUT_CYCLES);

    logic [9:0] cnt_q, cnt_d;

    assign fire = granted && (cnt_q == TIMEOUT_LIM);

    always_comb begin
        cnt_d = cnt_q;
        if (!granted || state_d == IDLE || fire || s_wbs_ack_i) begin
            cnt_d = '0;
        end else if (s_wbs_stb_o) begin
            cnt_d = cnt_q + 10'd1;
        end
    end

    always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
        if (!wb_rst_n_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end
`else
    assign fire = 1'b0;
`endif

    assign timeout_o = fire;
    assign gnt_o     = state_q;

    // Pure combinational routing; an abort cycle substitutes a local ack and withdraws the strobe.
    always_comb begin
        s_wbs_cyc_o  = 1'b0;
        s_wbs_stb_o  = 1'b0;
        s_wbs_we_o   = 1'b0;
        s_wbs_adr_o  = 32'h0;
        s_wbs_dat_o  = 32'h0;
        s_wbs_sel_o  = 4'h0;
        m0_wbs_ack_o = 1'b0;
        m0_wbs_dat_o = 32'h0;
        m1_wbs_ack_o = 1'b0;
        m1_wbs_dat_o = 32'h0;
        case (state_q)
            GNT0: begin
                s_wbs_cyc_o  = m0_wbs_cyc_i;
                s_wbs_stb_o  = m0_wbs_stb_i & ~fire;
                s_wbs_we_o   = m0_wbs_we_i;
                s_wbs_adr_o  = m0_wbs_adr_i;
                s_wbs_dat_o  = m0_wbs_dat_i;
                s_wbs_sel_o  = m0_wbs_sel_i;
                m0_wbs_ack_o = fire | s_wbs_ack_i;
                m0_wbs_dat_o = fire ? 32'hDEAD_BEEF : s_wbs_dat_i;
            end
            GNT1: begin
                s_wbs_cyc_o  = m1_wbs_cyc_i;
                s_wbs_stb_o  = m1_wbs_stb_i & ~fire;
                s_wbs_we_o   = m1_wbs_we_i;
                s_wbs_adr_o  = m1_wbs_adr_i;
                s_wbs_dat_o  = m1_wbs_dat_i;
                s_wbs_sel_o  = m1_wbs_sel_i;
                m1_wbs_ack_o = fire | s_wbs_ack_i;
                m1_wbs_dat_o = fire ? 32'hDEAD_BEEF : s_wbs_dat_i;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_uart_wb_arbiter.sv
// Self-checking bench for uart_wb_arbiter: directed scenarios plus randomized traffic against an ownership model.
module tb_uart_wb_arbiter;
    localparam int TOC = 8;
`ifdef UART_WB_ARB_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    logic        wb_clk_i, wb_rst_n_i;
    logic        m0_wbs_cyc_i, m0_wbs_stb_i, m0_wbs_we_i;
    logic [31:0] m0_wbs_adr_i, m0_wbs_dat_i, m0_wbs_dat_o;
    logic [3:0]  m0_wbs_sel_i;
    logic        m0_wbs_ack_o;
    logic        m1_wbs_cyc_i, m1_wbs_stb_i, m1_wbs_we_i;
    logic [31:0] m1_wbs_adr_i, m1_wbs_dat_i, m1_wbs_dat_o;
    logic [3:0]  m1_wbs_sel_i;
    logic        m1_wbs_ack_o;
    logic        s_wbs_cyc_o, s_wbs_stb_o, s_wbs_we_o;
    logic [31:0] s_wbs_adr_o, s_wbs_dat_o, s_wbs_dat_i;
    logic [3:0]  s_wbs_sel_o;
    logic        s_wbs_ack_i;
    logic [1:0]  gnt_o;
    logic        timeout_o;

    uart_wb_arbiter #(.TIMEOUT_CYCLES(TOC)) dut (
        .wb_clk_i(wb_clk_i), .wb_rst_n_i(wb_rst_n_i),
        .m0_wbs_cyc_i(m0_wbs_cyc_i), .m0_wbs_stb_i(m0_wbs_stb_i), .m0_wbs_we_i(m0_wbs_we_i),
        .m0_wbs_adr_i(m0_wbs_adr_i), .m0_wbs_dat_i(m0_wbs_dat_i), .m0_wbs_sel_i(m0_wbs_sel_i),
        .m0_wbs_dat_o(m0_wbs_dat_o), .m0_wbs_ack_o(m0_wbs_ack_o),
        .m1_wbs_cyc_i(m1_wbs_cyc_i), .m1_wbs_stb_i(m1_wbs_stb_i), .m1_wbs_we_i(m1_wbs_we_i),
        .m1_wbs_adr_i(m1_wbs_adr_i), .m1_wbs_dat_i(m1_wbs_dat_i), .m1_wbs_sel_i(m1_wbs_sel_i),
        .m1_wbs_dat_o(m1_wbs_dat_o), .m1_wbs_ack_o(m1_wbs_ack_o),
        .s_wbs_cyc_o(s_wbs_cyc_o), .s_wbs_stb_o(s_wbs_stb_o), .s_wbs_we_o(s_wbs_we_o),
        .s_wbs_adr_o(s_wbs_adr_o), .s_wbs_dat_o(s_wbs_dat_o), .s_wbs_sel_o(s_wbs_sel_o),
        .s_wbs_dat_i(s_wbs_dat_i), .s_wbs_ack_i(s_wbs_ack_i),
        .gnt_o(gnt_o), .timeout_o(timeout_o)
    );

    initial wb_clk_i = 1'b0;
    always #5 wb_clk_i = ~wb_clk_i;

    int checks = 0;
    int errors = 0;

    // Reference: who owns the slave (-1 none), who wins the next tie, stalled strobes so far.
    int owner  = -1;
    int prefer = 0;
    int stall  = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        owner  = -1;
        prefer = 0;
        stall  = 0;
    endtask

    function automatic bit model_fire();
        return TO_EN && owner >= 0 && stall == TOC;
    endfunction

    task automatic model_update();
        bit f;
        bit r0, r1;
        if (!wb_rst_n_i) begin
            model_reset();
            return;
        end
        f  = model_fire();
        r0 = m0_wbs_cyc_i && m0_wbs_stb_i;
        r1 = m1_wbs_cyc_i && m1_wbs_stb_i;
        if (owner < 0) begin
            if (r0 && r1)  owner = prefer;
            else if (r0)   owner = 0;
            else if (r1)   owner = 1;
            if (owner >= 0) prefer = 1 - owner;
            stall = 0;
        end else if (!(owner == 0 ? m0_wbs_cyc_i : m1_wbs_cyc_i)) begin
            owner = -1;
            stall = 0;
        end else if (f || s_wbs_ack_i) begin
            stall = 0;
        end else if (owner == 0 ? m0_wbs_stb_i : m1_wbs_stb_i) begin
            stall++;
        end
    endtask

    task automatic cmp_model();
        bit          f;
        logic        e_cyc, e_stb, e_we, e_a0, e_a1;
        logic [31:0] e_adr, e_dat, e_d0, e_d1;
        logic [3:0]  e_sel;
        logic [1:0]  e_gnt;
        f = model_fire();
        {e_cyc, e_stb, e_we, e_adr, e_dat, e_sel} = '0;
        {e_a0, e_a1, e_d0, e_d1} = '0;
        e_gnt = 2'b00;
        if (owner == 0) begin
            {e_cyc, e_stb, e_we} = {m0_wbs_cyc_i, m0_wbs_stb_i && !f, m0_wbs_we_i};
            {e_adr, e_dat, e_sel} = {m0_wbs_adr_i, m0_wbs_dat_i, m0_wbs_sel_i};
            e_a0  = f ? 1'b1 : s_wbs_ack_i;
            e_d0  = f ? 32'hDEAD_BEEF : s_wbs_dat_i;
            e_gnt = 2'b01;
        end else if (owner == 1) begin
            {e_cyc, e_stb, e_we} = {m1_wbs_cyc_i, m1_wbs_stb_i && !f, m1_wbs_we_i};
            {e_adr, e_dat, e_sel} = {m1_wbs_adr_i, m1_wbs_dat_i, m1_wbs_sel_i};
            e_a1  = f ? 1'b1 : s_wbs_ack_i;
            e_d1  = f ? 32'hDEAD_BEEF : s_wbs_dat_i;
            e_gnt = 2'b10;
        end
        chk("s_cyc", 32'(s_wbs_cyc_o), 32'(e_cyc));
        chk("s_stb", 32'(s_wbs_stb_o), 32'(e_stb));
        chk("s_we",  32'(s_wbs_we_o),  32'(e_we));
        chk("s_adr", s_wbs_adr_o, e_adr);
        chk("s_dat", s_wbs_dat_o, e_dat);
        chk("s_sel", 32'(s_wbs_sel_o), 32'(e_sel));
        chk("m0_ack", 32'(m0_wbs_ack_o), 32'(e_a0));
        chk("m0_dat", m0_wbs_dat_o, e_d0);
        chk("m1_ack", 32'(m1_wbs_ack_o), 32'(e_a1));
        chk("m1_dat", m1_wbs_dat_o, e_d1);
        chk("gnt", 32'(gnt_o), 32'(e_gnt));
        chk("timeout", 32'(timeout_o), 32'(f));
    endtask

    task automatic settle();
        @(negedge wb_clk_i);
        cmp_model();
    endtask

    task automatic edge_();
        @(posedge wb_clk_i);
        model_update();
        #1;
    endtask

    task automatic clear_masters();
        {m0_wbs_cyc_i, m0_wbs_stb_i, m0_wbs_we_i} = '0;
        {m1_wbs_cyc_i, m1_wbs_stb_i, m1_wbs_we_i} = '0;
        {m0_wbs_adr_i, m0_wbs_dat_i, m1_wbs_adr_i, m1_wbs_dat_i} = '0;
        m0_wbs_sel_i = 4'hF;
        m1_wbs_sel_i = 4'hF;
        s_wbs_ack_i  = 1'b0;
        s_wbs_dat_i  = 32'h0;
    endtask

    task automatic apply_reset();
        wb_rst_n_i = 1'b0;
        model_reset();
        settle();
        edge_();
        wb_rst_n_i = 1'b1;
    endtask

    initial begin
        int pulses;
        logic [31:0] beats [4];
        beats = '{32'h11, 32'h22, 32'h33, 32'h44};
        wb_rst_n_i = 1'b0;
        clear_masters();

        settle();
        chk("rst_gnt", 32'(gnt_o), 32'h0);
        chk("rst_timeout", 32'(timeout_o), 32'h0);
        edge_();
        wb_rst_n_i = 1'b1;

        // m0 single read, slave answers on the second granted cycle
        m0_wbs_cyc_i = 1'b1; m0_wbs_stb_i = 1'b1; m0_wbs_adr_i = 32'h3000_0000;
        settle(); chk("r20_idle_cyc", 32'(s_wbs_cyc_o), 32'h0); edge_();
        settle(); chk("r20_cyc", 32'(s_wbs_cyc_o), 32'h1);
        chk("r20_adr", s_wbs_adr_o, 32'h3000_0000); chk("r20_m1ack_a", 32'(m1_wbs_ack_o), 32'h0); edge_();
        s_wbs_ack_i = 1'b1; s_wbs_dat_i = 32'h0000_00A5;
        settle(); chk("r20_dat", m0_wbs_dat_o, 32'h0000_00A5); chk("r20_ack", 32'(m0_wbs_ack_o), 32'h1);
        chk("r20_gnt", 32'(gnt_o), 32'h1); chk("r20_m1ack_b", 32'(m1_wbs_ack_o), 32'h0); edge_();
        clear_masters();
        settle(); edge_(); settle(); edge_();

        // simultaneous requests: m0 first, dead cycle, then m1, then pointer back to m0
        apply_reset();
        m0_wbs_cyc_i = 1'b1; m0_wbs_stb_i = 1'b1; m0_wbs_adr_i = 32'h3000_0004;
        m1_wbs_cyc_i = 1'b1; m1_wbs_stb_i = 1'b1; m1_wbs_adr_i = 32'h3000_0008;
        settle(); chk("r21_wait", 32'(gnt_o), 32'h0); edge_();
        settle(); chk("r21_first", 32'(gnt_o), 32'h1); edge_();
        m0_wbs_cyc_i = 1'b0; m0_wbs_stb_i = 1'b0;
        settle(); edge_();
        settle(); chk("r21_dead", 32'(gnt_o), 32'h0); edge_();
        settle(); chk("r21_second", 32'(gnt_o), 32'h2); edge_();
        m1_wbs_cyc_i = 1'b0; m1_wbs_stb_i = 1'b0;
        settle(); edge_(); settle(); edge_();
        m0_wbs_cyc_i = 1'b1; m0_wbs_stb_i = 1'b1;
        m1_wbs_cyc_i = 1'b1; m1_wbs_stb_i = 1'b1;
        settle(); edge_();
        settle(); chk("r21_alt", 32'(gnt_o), 32'h1); edge_();
        m0_wbs_cyc_i = 1'b0; m0_wbs_stb_i = 1'b0;
        settle(); edge_(); settle(); edge_();
        settle(); chk("r22_gnt_start", 32'(gnt_o), 32'h2); edge_();

        // m1 4-beat block write while m0 waits
        m0_wbs_cyc_i = 1'b1; m0_wbs_stb_i = 1'b1;
        m1_wbs_we_i = 1'b1; s_wbs_ack_i = 1'b1;
        for (int i = 0; i < 4; i++) begin
            m1_wbs_dat_i = beats[i];
            settle();
            chk("r22_gnt", 32'(gnt_o), 32'h2);
            chk("r22_wdat", s_wbs_dat_o, beats[i]);
            chk("r22_m0ack", 32'(m0_wbs_ack_o), 32'h0);
            edge_();
        end
        s_wbs_ack_i = 1'b0;
        m1_wbs_cyc_i = 1'b0; m1_wbs_stb_i = 1'b0; m1_wbs_we_i = 1'b0;
        settle(); edge_(); settle(); edge_();
        settle(); chk("r22_m0_served", 32'(gnt_o), 32'h1); edge_();

        // async reset in GNT0 with m1 pending
        m1_wbs_cyc_i = 1'b1; m1_wbs_stb_i = 1'b1; s_wbs_ack_i = 1'b1; s_wbs_dat_i = 32'h55;
        settle(); chk("r23_pre", 32'(gnt_o), 32'h1);
        #2 wb_rst_n_i = 1'b0;
        model_reset();
        #1;
        chk("r23_cyc", 32'(s_wbs_cyc_o), 32'h0); chk("r23_gnt", 32'(gnt_o), 32'h0);
        chk("r23_ack", 32'(m0_wbs_ack_o), 32'h0); chk("r23_adr", s_wbs_adr_o, 32'h0);
        chk("r23_mdat", m0_wbs_dat_o, 32'h0);
        m0_wbs_cyc_i = 1'b0; m0_wbs_stb_i = 1'b0; s_wbs_ack_i = 1'b0;
        edge_(); settle(); edge_();
        wb_rst_n_i = 1'b1;
        settle(); chk("r23_rel", 32'(gnt_o), 32'h0); edge_();
        settle(); chk("r23_m1", 32'(gnt_o), 32'h2); chk("r23_m1cyc", 32'(s_wbs_cyc_o), 32'h1); edge_();
        clear_masters();
        settle(); edge_(); settle(); edge_();

        // stalled slave: abort only when the watchdog is built in
        apply_reset();
        m0_wbs_cyc_i = 1'b1; m0_wbs_stb_i = 1'b1; s_wbs_dat_i = 32'h1234_5678;
        settle(); edge_();
        pulses = 0;
        for (int k = 1; k <= 12; k++) begin
            bit exp_f;
            exp_f = TO_EN && k == TOC + 1;
            settle();
            chk("r24_ack", 32'(m0_wbs_ack_o), 32'(exp_f));
            chk("r24_dat", m0_wbs_dat_o, exp_f ? 32'hDEAD_BEEF : 32'h1234_5678);
            chk("r24_gnt", 32'(gnt_o), 32'h1);
            if (timeout_o) pulses++;
            edge_();
        end
        chk("r24_pulses", 32'(pulses), TO_EN ? 32'h1 : 32'h0);
        clear_masters();
        settle(); edge_(); settle(); edge_();

        // randomized traffic; periodic windows of a silent slave
        for (int i = 0; i < 1500; i++) begin
            if (m0_wbs_cyc_i) begin
                if ($urandom_range(3) == 0) m0_wbs_cyc_i = 1'b0;
            end else if ($urandom_range(2) == 0) m0_wbs_cyc_i = 1'b1;
            if (m1_wbs_cyc_i) begin
                if ($urandom_range(3) == 0) m1_wbs_cyc_i = 1'b0;
            end else if ($urandom_range(2) == 0) m1_wbs_cyc_i = 1'b1;
            m0_wbs_stb_i = m0_wbs_cyc_i && ($urandom_range(3) != 0);
            m1_wbs_stb_i = m1_wbs_cyc_i && ($urandom_range(3) != 0);
            m0_wbs_we_i  = 1'($urandom_range(1));
            m1_wbs_we_i  = 1'($urandom_range(1));
            m0_wbs_adr_i = $urandom; m0_wbs_dat_i = $urandom; m0_wbs_sel_i = 4'($urandom_range(15));
            m1_wbs_adr_i = $urandom; m1_wbs_dat_i = $urandom; m1_wbs_sel_i = 4'($urandom_range(15));
            s_wbs_ack_i  = (i % 200 >= 60) && ($urandom_range(2) == 0);
            s_wbs_dat_i  = $urandom;
            settle();
            edge_();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
